mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Two-master arbiter directly upstream of one port of the dual-port SRAM wrapper. It merges two OBI-style request streams onto a single req/gnt/rvalid memory port, for example the scalar LSU and the vector LSU. It tracks outstanding transactions in an in-order ID FIFO and routes each response back to the master that issued it. It is transparent to the memory's fixed one-cycle read latency and also tolerates a downstream port with longer latency or a stalling grant.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
ADDR_WIDTH, 32, byte address width.
MAX_OUTST, 4, maximum accepted-but-unanswered transactions; power of two, at least 1.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_ni  in  1  synchronous active-low reset.
m0_req  in  1  master 0 request.
m0_addr  in  ADDR_WIDTH  master 0 byte address.
m0_we  in  1  master 0 write enable.
m0_be  in  DATA_WIDTH/8  master 0 byte enables.
m0_wdata  in  DATA_WIDTH  master 0 write data.
m0_gnt  out  1  master 0 request accepted this cycle.
m0_rvalid  out  1  master 0 response valid.
m0_err  out  1  master 0 response error; valid only with m0_rvalid.
m0_rdata  out  DATA_WIDTH  master 0 read data.
m1_*  same set as m0_*, for master 1.
mem_req / mem_addr / mem_we / mem_be / mem_wdata  out  1 / ADDR_WIDTH / 1 / DATA_WIDTH/8 / DATA_WIDTH  request to the memory port.
mem_gnt  in  1  memory accepted the request.
mem_rvalid  in  1  memory response valid.
mem_err  in  1  memory response error.
mem_rdata  in  DATA_WIDTH  memory read data.
spurious_rvalid  out  1  sticky flag: mem_rvalid arrived with no transaction outstanding.

Behaviour:
- Reset (rst_ni=0 at the clock edge): FIFO count=0, read and write pointers=0, lock cleared, round-robin pointer favours m0, spurious_rvalid=0. While rst_ni=0, mem_req, m0_gnt and m1_gnt are forced to 0. m*_rvalid and m*_err are 0 because the FIFO is empty.
- Request path is combinational with zero added latency. sel is the chosen master. mem_req = sel_req && !full. mem_addr, mem_we, mem_be and mem_wdata are muxed from sel.
- Arbitration without the optional feature: fixed priority, m0 over m1.
- Lock: if mem_req=1 and mem_gnt=0, sel is registered and held on following cycles until that request is granted. The lock releases if the locked master drops req, which is a protocol violation that is tolerated.
- Grant: mX_gnt = mem_gnt && mem_req && sel==X. The non-selected master's gnt is 0.
- Push: on each accepted grant, the 1-bit master ID is written to the FIFO at the write pointer.
- Full: when count==MAX_OUTST, mem_req=0 and both gnts are 0. A simultaneous pop does not unblock the same cycle; the full check uses the registered count.
- Response path is combinational. On mem_rvalid with count>0, the head ID selects the master. That master gets rvalid=1 and err=mem_err; the other gets rvalid=0. mem_rdata drives both m0_rdata and m1_rdata unconditionally.
- Pop: happens on every mem_rvalid while count>0.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo MAX_OUTST.
- Empty: mem_rvalid with count==0 sets spurious_rvalid (cleared only by reset). Both m*_rvalid stay 0 and the count does not underflow.
- Ordering: responses return strictly in grant order. This matches the in-order downstream memory port.
- Reset mid-operation discards all outstanding IDs. Responses arriving after reset are handled as spurious.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A 1-bit last-granted register is updated only on an accepted grant. When both masters request and no lock is held, the master not granted last wins. Reset value is last-granted=m1, so m0 wins first.
- Undefined: fixed priority, m0 over m1. No last-granted register is built.
- Lock, FIFO and response behaviour are identical in both builds.

Test Plan:
- Single read, MAX_OUTST=4, mem_gnt tied 1, memory with 1-cycle latency: m1 reads addr 0x10 → m1_gnt=1 the same cycle; one cycle later m1_rvalid=1 with the memory's data, m0_rvalid=0.
- Both masters request every cycle for 4 cycles. Without the macro: grant sequence m0,m0,m0,m0. With ARB_ROUND_ROBIN_EN: m0,m1,m0,m1. Responses are routed in the same order.
- Full: mem_gnt=1, mem_rvalid held 0 → after 4 grants count=4 and mem_req=0. One mem_rvalid → the first requester gets rvalid; on the next cycle mem_req re-asserts.
- Stall and lock: m1 requests alone and mem_gnt=0 for 3 cycles; m0 then requests at cycle 1 → sel stays m1 and mem_addr stays m1_addr. When mem_gnt=1, m1_gnt=1, and m0 is granted the next cycle.
- Error routing: m0 writes with be=4'b0011, memory returns mem_err=1 → m0_rvalid=1 and m0_err=1; m1_rvalid=0 and m1_err=0.
- Spurious and reset: mem_rvalid pulsed while empty → spurious_rvalid=1 and stays 1. Then 2 transactions are outstanding, reset is pulsed for one cycle, and 2 mem_rvalid follow → no m*_rvalid, count stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges two OBI-style request streams onto one memory port.
// Outstanding transactions are tracked in an in-order ID FIFO so that every
// response is routed back to the master that issued the request.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration between
// the two masters; without it, master 0 has fixed priority over master 1.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                    clk,
    input  logic                    rst_ni,

    input  logic                    m0_req,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic                    m0_err,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic                    m1_err,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic                    mem_err,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    spurious_rvalid
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

    typedef enum logic {
        MASTER_0 = 1'b0,
        MASTER_1 = 1'b1
    } master_e;

    master_e           sel;
    logic              sel_req;
    logic              lock_q;
    master_e           lock_sel_q;
    logic              lock_valid;
    logic              full;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    master_e           id_fifo_q [MAX_OUTST];
    master_e           head_id;
    logic              spurious_q;

`ifdef ARB_ROUND_ROBIN_EN
    master_e           last_q;
`endif

    // Advance a FIFO pointer, wrapping at MAX_OUTST.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A lock only holds while the locked master keeps requesting.
    always_comb begin
        lock_valid = 1'b0;
        if (lock_q) begin
            lock_valid = (lock_sel_q == MASTER_0) ? m0_req : m1_req;
        end
    end

    // Master selection: held lock first, then arbitration between requesters.
    always_comb begin
        sel = MASTER_0;
        if (lock_valid) begin
            sel = lock_sel_q;
        end else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel = (last_q == MASTER_0) ? MASTER_1 : MASTER_0;
`else
            sel = MASTER_0;
`endif
        end else if (m1_req) begin
            sel = MASTER_1;
        end
    end

    // Request path: zero-latency mux towards the memory port.
    always_comb begin
        sel_req   = (sel == MASTER_0) ? m0_req : m1_req;
        full      = (count_q == CNT_FULL);
        mem_req   = rst_ni && sel_req && !full;
        mem_addr  = (sel == MASTER_0) ? m0_addr  : m1_addr;
        mem_we    = (sel == MASTER_0) ? m0_we    : m1_we;
        mem_be    = (sel == MASTER_0) ? m0_be    : m1_be;
        mem_wdata = (sel == MASTER_0) ? m0_wdata : m1_wdata;
        push      = mem_req && mem_gnt;
        m0_gnt    = push && (sel == MASTER_0);
        m1_gnt    = push && (sel == MASTER_1);
    end

    // Response path: the FIFO head names the master owning this response.
    always_comb begin
        pop       = mem_rvalid && (count_q != '0);
        head_id   = id_fifo_q[rptr_q];
        m0_rvalid = pop && (head_id == MASTER_0);
        m1_rvalid = pop && (head_id == MASTER_1);
        m0_err    = m0_rvalid && mem_err;
        m1_err    = m1_rvalid && mem_err;
        m0_rdata  = mem_rdata;
        m1_rdata  = mem_rdata;
    end

    // Lock register: remember the selection while its request is stalled.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_sel_q <= MASTER_0;
        end else if (mem_req && !mem_gnt) begin
            lock_q     <= 1'b1;
            lock_sel_q <= sel;
        end else begin
            lock_q     <= 1'b0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Last-granted master, updated only on an accepted grant.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            last_q <= MASTER_1;
        end else if (push) begin
            last_q <= sel;
        end
    end
`endif

    // ID FIFO storage: written at the write pointer on each accepted grant.
    always_ff @(posedge clk) begin
        if (push) begin
            id_fifo_q[wptr_q] <= sel;
        end
    end

    // ID FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky flag for responses that arrive with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            spurious_q <= 1'b0;
        end else if (mem_rvalid && (count_q == '0)) begin
            spurious_q <= 1'b1;
        end
    end

    assign spurious_rvalid = spurious_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a queue-based reference model
// checked on every cycle, plus hand-computed spot checks.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW/8-1:0] m0_be;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW/8-1:0] m1_be;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
    logic [AW-1:0] mem_addr;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          spurious_rvalid;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_OUTST (MO)
    ) dut (
        .clk            (clk),
        .rst_ni         (rst_ni),
        .m0_req         (m0_req),
        .m0_addr        (m0_addr),
        .m0_we          (m0_we),
        .m0_be          (m0_be),
        .m0_wdata       (m0_wdata),
        .m0_gnt         (m0_gnt),
        .m0_rvalid      (m0_rvalid),
        .m0_err         (m0_err),
        .m0_rdata       (m0_rdata),
        .m1_req         (m1_req),
        .m1_addr        (m1_addr),
        .m1_we          (m1_we),
        .m1_be          (m1_be),
        .m1_wdata       (m1_wdata),
        .m1_gnt         (m1_gnt),
        .m1_rvalid      (m1_rvalid),
        .m1_err         (m1_err),
        .m1_rdata       (m1_rdata),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_err        (mem_err),
        .mem_rdata      (mem_rdata),
        .spurious_rvalid(spurious_rvalid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: queue of master IDs in grant order.
    int q[$];
    int lock_m = -1;
    int last_m = 1;
    bit spur   = 1'b0;
    bit armed  = 1'b0;

    // Inputs change just after posedge, so at negedge they equal what the
    // next posedge samples: compare, then advance the model for that edge.
    always @(negedge clk) begin : model_cmp
        int  r[2];
        int  ch;
        bit  full, e_req, e_any, e_rv0, e_rv1, e_g0, e_g1;
        r[0] = int'(m0_req);
        r[1] = int'(m1_req);
        if (lock_m >= 0 && r[lock_m] != 0) ch = lock_m;
`ifdef ARB_ROUND_ROBIN_EN
        else if (r[0] != 0 && r[1] != 0) ch = 1 - last_m;
`else
        else if (r[0] != 0 && r[1] != 0) ch = 0;
`endif
        else if (r[1] != 0) ch = 1;
        else ch = 0;
        full  = (q.size() == MO);
        e_req = (rst_ni === 1'b1) && (r[ch] != 0) && !full;
        e_g0  = e_req && mem_gnt && (ch == 0);
        e_g1  = e_req && mem_gnt && (ch == 1);
        e_any = (mem_rvalid === 1'b1) && (q.size() > 0);
        e_rv0 = e_any && (q[0] == 0);
        e_rv1 = e_any && (q[0] == 1);
        if (armed) begin
            chk("mdl_mem_req", mem_req, e_req);
            chk("mdl_m0_gnt", m0_gnt, e_g0);
            chk("mdl_m1_gnt", m1_gnt, e_g1);
            chk("mdl_m0_rvalid", m0_rvalid, e_rv0);
            chk("mdl_m1_rvalid", m1_rvalid, e_rv1);
            chk("mdl_spurious", spurious_rvalid, spur);
            chk("mdl_m0_rdata", m0_rdata, mem_rdata);
            chk("mdl_m1_rdata", m1_rdata, mem_rdata);
            if (e_req) begin
                chk("mdl_mem_addr", mem_addr, ch ? m1_addr : m0_addr);
                chk("mdl_mem_we", mem_we, ch ? m1_we : m0_we);
                chk("mdl_mem_be", mem_be, ch ? m1_be : m0_be);
                chk("mdl_mem_wdata", mem_wdata, ch ? m1_wdata : m0_wdata);
            end
            if (e_rv0) chk("mdl_m0_err", m0_err, mem_err);
            if (e_rv1) chk("mdl_m1_err", m1_err, mem_err);
        end
        if (rst_ni !== 1'b1) begin
            q.delete();
            lock_m = -1;
            last_m = 1;
            spur   = 1'b0;
            armed  = 1'b1;
        end else begin
            if (mem_rvalid === 1'b1 && q.size() == 0) spur = 1'b1;
            if (e_any) void'(q.pop_front());
            if (e_req && mem_gnt) begin
                q.push_back(ch);
                last_m = ch;
            end
            lock_m = (e_req && !mem_gnt) ? ch : -1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m1_req = 1'b0;
        m0_we  = 1'b0; m1_we  = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    endtask

    int exp_seq[4];

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        rst_ni = 1'b0;
        idle();
        m0_addr = '0; m1_addr = '0; m0_be = 4'hF; m1_be = 4'hF;
        m0_wdata = '0; m1_wdata = '0; mem_rdata = '0;
        step(); step();
        #1;
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_spurious", spurious_rvalid, 1'b0);
        rst_ni = 1'b1;
        step();
        #1;
        chk("reset_m0_rvalid", m0_rvalid, 1'b0);
        step();

        // Single read by m1 with one-cycle memory latency.
        m1_req = 1'b1; m1_addr = 32'h10; mem_gnt = 1'b1; #1;
        chk("rd_m1_gnt", m1_gnt, 1'b1);
        chk("rd_m0_gnt", m0_gnt, 1'b0);
        chk("rd_addr", mem_addr, 32'h10);
        step();
        m1_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0010; #1;
        chk("rd_m1_rvalid", m1_rvalid, 1'b1);
        chk("rd_m0_rvalid", m0_rvalid, 1'b0);
        chk("rd_m1_rdata", m1_rdata, 32'hCAFE_0010);
        step(); idle(); step();

        // Both masters request for four cycles, responses one cycle later.
        for (int k = 0; k < 5; k++) begin
            m0_req = (k < 4); m1_req = (k < 4);
            m0_addr = 32'h100 + k; m1_addr = 32'h200 + k;
            mem_gnt = (k < 4); mem_rvalid = (k > 0); mem_rdata = 32'hD000 + k;
            #1;
            if (k < 4) begin
                chk($sformatf("arb_m0_gnt%0d", k), m0_gnt, exp_seq[k] == 0);
                chk($sformatf("arb_m1_gnt%0d", k), m1_gnt, exp_seq[k] == 1);
            end
            if (k > 0) begin
                chk($sformatf("arb_m0_rsp%0d", k), m0_rvalid, exp_seq[k-1] == 0);
                chk($sformatf("arb_m1_rsp%0d", k), m1_rvalid, exp_seq[k-1] == 1);
            end
            step();
        end
        idle(); step();

        // Fill the FIFO: m1 first, then three m0 grants.
        m1_req = 1'b1; m1_addr = 32'h500; mem_gnt = 1'b1;
        step();
        m1_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m0_req = 1'b1; m0_addr = 32'h600 + k;
            step();
        end
        m0_addr = 32'h700; #1;
        chk("full_mem_req", mem_req, 1'b0);
        chk("full_m0_gnt", m0_gnt, 1'b0);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hF011; #1;
        chk("full_pop_m1_rvalid", m1_rvalid, 1'b1);
        chk("full_pop_m0_rvalid", m0_rvalid, 1'b0);
        chk("full_same_cycle_req", mem_req, 1'b0);
        step();
        mem_rvalid = 1'b0; #1;
        chk("full_release_req", mem_req, 1'b1);
        chk("full_release_gnt", m0_gnt, 1'b1);
        step();
        m0_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
        repeat (4) step();
        idle(); step();

        // Stall and lock: m1 stalled, m0 arrives, lock holds m1.
        m1_req = 1'b1; m1_addr = 32'h300; mem_gnt = 1'b0; #1;
        chk("lock_addr0", mem_addr, 32'h300);
        chk("lock_m1_gnt0", m1_gnt, 1'b0);
        step();
        m0_req = 1'b1; m0_addr = 32'h400; #1;
        chk("lock_addr1", mem_addr, 32'h300);
        chk("lock_m0_gnt1", m0_gnt, 1'b0);
        step(); #1;
        chk("lock_addr2", mem_addr, 32'h300);
        step();
        mem_gnt = 1'b1; #1;
        chk("lock_m1_gnt", m1_gnt, 1'b1);
        chk("lock_m0_held", m0_gnt, 1'b0);
        step();
        m1_req = 1'b0; #1;
        chk("lock_next_m0_gnt", m0_gnt, 1'b1);
        chk("lock_next_addr", mem_addr, 32'h400);
        step();
        idle(); mem_rvalid = 1'b1; #1;
        chk("lock_rsp_m1", m1_rvalid, 1'b1);
        step(); #1;
        chk("lock_rsp_m0", m0_rvalid, 1'b1);
        step(); idle(); step();

        // Locked master drops its request: lock releases.
        m1_req = 1'b1; m1_addr = 32'h310; mem_gnt = 1'b0;
        step();
        m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h410; #1;
        chk("drop_addr", mem_addr, 32'h410);
        step(); idle(); step();

        // Write with error response routed to m0.
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'b0011; m0_wdata = 32'h1234_5678;
        m0_addr = 32'h800; mem_gnt = 1'b1; #1;
        chk("err_we", mem_we, 1'b1);
        chk("err_be", mem_be, 4'b0011);
        chk("err_wdata", mem_wdata, 32'h1234_5678);
        chk("err_gnt", m0_gnt, 1'b1);
        step();
        idle(); mem_rvalid = 1'b1; mem_err = 1'b1; #1;
        chk("err_m0_rvalid", m0_rvalid, 1'b1);
        chk("err_m0_err", m0_err, 1'b1);
        chk("err_m1_rvalid", m1_rvalid, 1'b0);
        chk("err_m1_err", m1_err, 1'b0);
        step(); idle(); step();

        // Spurious response while empty, then reset with two outstanding.
        chk("spur_before", spurious_rvalid, 1'b0);
        mem_rvalid = 1'b1; #1;
        chk("spur_m0_rvalid", m0_rvalid, 1'b0);
        step();
        mem_rvalid = 1'b0; #1;
        chk("spur_set", spurious_rvalid, 1'b1);
        repeat (3) step();
        chk("spur_sticky", spurious_rvalid, 1'b1);
        m0_req = 1'b1; m0_addr = 32'h900; mem_gnt = 1'b1;
        step();
        m0_addr = 32'h904;
        step();
        rst_ni = 1'b0; #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_m0_gnt", m0_gnt, 1'b0);
        step();
        rst_ni = 1'b1; idle(); #1;
        chk("rst_spur_clr", spurious_rvalid, 1'b0);
        mem_rvalid = 1'b1; #1;
        chk("post_rst_m0_rv0", m0_rvalid, 1'b0);
        chk("post_rst_m1_rv0", m1_rvalid, 1'b0);
        step(); #1;
        chk("post_rst_m0_rv1", m0_rvalid, 1'b0);
        step();
        idle(); #1;
        chk("post_rst_spur", spurious_rvalid, 1'b1);
        step();

        // A fresh read still routes correctly after the discarded responses.
        m1_req = 1'b1; m1_addr = 32'hA0; mem_gnt = 1'b1; #1;
        chk("fresh_m1_gnt", m1_gnt, 1'b1);
        step();
        idle(); mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D; #1;
        chk("fresh_m1_rvalid", m1_rvalid, 1'b1);
        chk("fresh_m0_rvalid", m0_rvalid, 1'b0);
        step(); idle();
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
